// File: rtl/store_data_buffer.sv
// Store data buffer: it aligns MEM-stage store data to byte lanes and queues the stores
// in a FIFO that drains to the D-cache in issue order. It also detects load/store word conflicts.
module store_data_buffer #(
  parameter int DEPTH  = 4,
  parameter int NSRC   = 2,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [1:0]                 st_size,
  input  logic [NSRC*32-1:0]         src_data,
  input  logic [$clog2(NSRC)-1:0]    src_sel,
  output logic                       st_stall,
  output logic                       st_err,
  output logic                       dc_valid,
  input  logic                       dc_ready,
  output logic [ADDR_W-1:0]          dc_addr,
  output logic [31:0]                dc_wdata,
  output logic [3:0]                 dc_be,
  input  logic                       ld_valid,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       ld_hazard,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WA = ADDR_W - 2;

  typedef struct packed {
    logic [WA-1:0] waddr;
    logic [31:0]   data;
    logic [3:0]    be;
  } ent_t;

  ent_t             mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    wp_q, rp_q;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;

  logic [31:0]      src_w [NSRC];
  logic [31:0]      sel_data;
  ent_t             new_e;
  logic             mis, full, empty, push, pop;
  logic [DEPTH-1:0] hit;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    assign src_w[k] = src_data[32*k +: 32];
  end

  assign sel_data = (32'(src_sel) < NSRC) ? src_w[src_sel] : src_w[0];

  // Replicate the narrow data across the lanes so the byte enables select the right copy.
  always_comb begin
    new_e.waddr = st_addr[ADDR_W-1:2];
    new_e.data  = sel_data;
    new_e.be    = 4'b1111;
    mis         = 1'b0;
    case (st_size)
      2'b00: begin
        new_e.data = {4{sel_data[7:0]}};
        new_e.be   = 4'b0001 << st_addr[1:0];
      end
      2'b01: begin
        new_e.data = {2{sel_data[15:0]}};
        new_e.be   = 4'b0011 << st_addr[1:0];
        mis        = st_addr[0];
      end
      2'b10:   mis = |st_addr[1:0];
      default: mis = 1'b1;
    endcase
  end

  // The stall path uses registered occupancy only, so a full buffer stalls even while it pops.
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign st_stall = st_valid & full;
  assign push     = st_valid & ~full & ~mis;
  assign pop      = ~empty & dc_ready;
  assign err_d    = st_valid & ~full & mis;

  always_comb begin
    count_d = count_q;
    if (push & ~pop)      count_d = count_q + 1'b1;
    else if (~push & pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      vld_q   <= '0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
      if (push) begin
        wp_q        <= wp_q + 1'b1;
        vld_q[wp_q] <= 1'b1;
      end
      if (pop) begin
        rp_q        <= rp_q + 1'b1;
        vld_q[rp_q] <= 1'b0;
      end
    end
  end

  // The payload needs no reset because vld_q and count_q gate every use of it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= new_e;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit[i] = vld_q[i] & (mem_q[i].waddr == ld_addr[ADDR_W-1:2]);
  end

  assign ld_hazard = ld_valid & (|hit);
  assign dc_valid  = ~empty;
  assign dc_addr   = {mem_q[rp_q].waddr, 2'b00};
  assign dc_wdata  = mem_q[rp_q].data;
  assign dc_be     = mem_q[rp_q].be;
  assign st_err    = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_store_data_buffer.sv
// Directed bench for store_data_buffer. A scoreboard queue holds the D-cache writes that
// the stores should produce. A negedge monitor compares each accepted D-cache write with that queue.
module tb_store_data_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [1:0]  st_size;
  logic [95:0] src_data;
  logic [1:0]  src_sel;
  logic        st_stall, st_err, dc_valid, dc_ready;
  logic [31:0] dc_addr, dc_wdata;
  logic [3:0]  dc_be;
  logic        ld_valid, ld_hazard;
  logic [31:0] ld_addr;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } exp_t;

  exp_t sbq[$];
  int   ntests = 0;
  int   nfail  = 0;

  store_data_buffer #(.DEPTH(4), .NSRC(3), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_addr(st_addr), .st_size(st_size),
    .src_data(src_data), .src_sel(src_sel), .st_stall(st_stall), .st_err(st_err),
    .dc_valid(dc_valid), .dc_ready(dc_ready), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_be(dc_be), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Lane placement and alignment rules derived from the store size and address.
  function automatic bit model(input logic [31:0] a, input logic [1:0] sz,
                               input logic [31:0] d, output exp_t e);
    e.a = {a[31:2], 2'b00};
    case (sz)
      2'b00: begin e.d = {4{d[7:0]}};  e.be = 4'b0001 << a[1:0]; return 1'b1;       end
      2'b01: begin e.d = {2{d[15:0]}}; e.be = 4'b0011 << a[1:0]; return !a[0];      end
      2'b10: begin e.d = d;            e.be = 4'b1111;           return a[1:0] == 0; end
      default: begin e.d = '0;         e.be = '0;                return 1'b0;       end
    endcase
  endfunction

  task automatic set_src(input logic [1:0] sel, input logic [31:0] d);
    int eff;
    eff = (sel < 3) ? int'(sel) : 0;
    for (int k = 0; k < 3; k++) src_data[32*k +: 32] = (k == eff) ? d : ~d;
    src_sel = sel;
  endtask

  task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] sel,
                       input logic [31:0] d, input bit kick);
    exp_t e;
    bit   acc;
    acc = 1'b0;
    set_src(sel, d);
    st_valid = 1'b1; st_addr = a; st_size = sz;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!st_stall) begin acc = 1'b1; break; end
      @(posedge clk); #1;
      if (kick) dc_ready = 1'b1;
    end
    chk("store_accept_bound", 32'(acc), 32'd1);
    if (acc && model(a, sz, d, e)) sbq.push_back(e);
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    dc_ready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (count == 0) begin done = 1'b1; break; end
    end
    chk("drain_bound", 32'(done), 32'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && dc_valid && dc_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_dc_write", dc_addr, 32'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        chk("dc_addr", dc_addr, e.a);
        chk("dc_wdata", dc_wdata, e.d);
        chk("dc_be", 32'(dc_be), 32'(e.be));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_size = '0; src_data = '0; src_sel = '0;
    dc_ready = 1'b1; ld_valid = 1'b1; ld_addr = '0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dc_valid", 32'(dc_valid), 32'd0);
    chk("rst_st_err", 32'(st_err), 32'd0);
    chk("rst_ld_hazard", 32'(ld_hazard), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; ld_valid = 1'b0;

    // Byte store in the first cycle after reset, taken from source 1.
    issue(32'h103, 2'b00, 2'd1, 32'h0000_00AB, 1'b0);
    chk("byte_dc_valid", 32'(dc_valid), 32'd1);
    chk("byte_dc_addr", dc_addr, 32'h100);
    chk("byte_dc_wdata", dc_wdata, 32'hABAB_ABAB);
    chk("byte_dc_be", 32'(dc_be), 32'h8);
    @(posedge clk); #1;
    chk("byte_count_back", 32'(count), 32'd0);

    // Source 2 and an out-of-range select, which falls back to source 0.
    issue(32'h10, 2'b10, 2'd2, 32'hCAFE_F00D, 1'b0);
    issue(32'h14, 2'b10, 2'd3, 32'h1234_5678, 1'b0);
    drain();

    // Aligned half store accepted; misaligned word and reserved size give st_err pulses.
    dc_ready = 1'b0;
    issue(32'h202, 2'b01, 2'd0, 32'h5566_1234, 1'b0);
    chk("half_dc_be", 32'(dc_be), 32'hC);
    chk("half_dc_wdata", dc_wdata, 32'h1234_1234);
    chk("half_dc_addr", dc_addr, 32'h200);
    issue(32'h205, 2'b10, 2'd0, 32'h1, 1'b0);
    chk("mis_word_err", 32'(st_err), 32'd1);
    chk("mis_word_count", 32'(count), 32'd1);
    @(posedge clk); #1;
    chk("mis_err_one_cycle", 32'(st_err), 32'd0);
    issue(32'h208, 2'b11, 2'd0, 32'h2, 1'b0);
    chk("rsv_size_err", 32'(st_err), 32'd1);

    // Load hazard checks against buffered word addresses 0x200 and 0x300.
    issue(32'h300, 2'b10, 2'd0, 32'h3333_0000, 1'b0);
    ld_valid = 1'b1; ld_addr = 32'h302; #1;
    chk("hazard_hit", 32'(ld_hazard), 32'd1);
    ld_addr = 32'h304; #1;
    chk("hazard_miss", 32'(ld_hazard), 32'd0);
    ld_addr = 32'h203; #1;
    chk("hazard_head", 32'(ld_hazard), 32'd1);
    ld_valid = 1'b0; ld_addr = 32'h300; #1;
    chk("hazard_no_ld_valid", 32'(ld_hazard), 32'd0);
    drain();

    // A store being written in the current cycle does not raise a hazard yet.
    dc_ready = 1'b0; ld_valid = 1'b1; ld_addr = 32'h400;
    set_src(2'd0, 32'h77); st_valid = 1'b1; st_addr = 32'h400; st_size = 2'b10;
    @(negedge clk);
    chk("hazard_same_cycle_write", 32'(ld_hazard), 32'd0);
    e = '{a: 32'h400, d: 32'h77, be: 4'hF};
    sbq.push_back(e);
    @(posedge clk); #1;
    st_valid = 1'b0;
    chk("hazard_after_write", 32'(ld_hazard), 32'd1);
    ld_valid = 1'b0;
    drain();

    // Fill to DEPTH and stall the fifth store; it is accepted one cycle after the first remove.
    dc_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(32'h500 + 32'(4*i), 2'b10, 2'd0, 32'hA0 + 32'(i), 1'b0);
    chk("full_count", 32'(count), 32'd4);
    set_src(2'd0, 32'hA4); st_valid = 1'b1; st_addr = 32'h510; st_size = 2'b10;
    @(negedge clk);
    chk("full_stall", 32'(st_stall), 32'd1);
    chk("full_dc_addr_hold", dc_addr, 32'h500);
    @(posedge clk); #1;
    dc_ready = 1'b1;
    @(negedge clk);
    chk("stall_before_pop", 32'(st_stall), 32'd1);
    @(negedge clk);
    chk("stall_released", 32'(st_stall), 32'd0);
    chk("count_after_pop", 32'(count), 32'd3);
    e = '{a: 32'h510, d: 32'hA4, be: 4'hF};
    sbq.push_back(e);
    @(posedge clk); #1;
    st_valid = 1'b0;
    chk("count_push_pop", 32'(count), 32'd3);
    drain();

    // A full buffer with dc_ready high still stalls; afterwards the pointers wrap several times.
    dc_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(32'h600 + 32'(4*i), 2'b10, 2'd1, 32'hB0 + 32'(i), 1'b0);
    dc_ready = 1'b1;
    set_src(2'd0, 32'hB4); st_valid = 1'b1; st_addr = 32'h610; st_size = 2'b10;
    @(negedge clk);
    chk("full_ready_stall", 32'(st_stall), 32'd1);
    chk("full_ready_count", 32'(count), 32'd4);
    @(negedge clk);
    chk("full_ready_count_dec", 32'(count), 32'd3);
    chk("full_ready_accept", 32'(st_stall), 32'd0);
    e = '{a: 32'h610, d: 32'hB4, be: 4'hF};
    sbq.push_back(e);
    @(posedge clk); #1;
    st_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      dc_ready = (i % 3 != 2);
      issue(32'h700 + 32'(4*i), 2'(i % 3), 2'(i % 4), $urandom, 1'b1);
    end
    drain();

    // Reset with three entries pending drops them without any D-cache write.
    dc_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(32'h800 + 32'(4*i), 2'b10, 2'd0, 32'hC0 + 32'(i), 1'b0);
    chk("pre_reset_count", 32'(count), 32'd3);
    ld_valid = 1'b1; ld_addr = 32'h800;
    rst_n = 1'b0; #1;
    chk("reset_dc_valid", 32'(dc_valid), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_ld_hazard", 32'(ld_hazard), 32'd0);
    sbq.delete();
    dc_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; ld_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 32'(dc_valid), 32'd0);
    @(posedge clk); #1;
    issue(32'h900, 2'b01, 2'd2, 32'h0000_BEEF, 1'b0);
    drain();
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/store_data_buffer.md
STORE_DATA_BUFFER -- requirements
Module: store_data_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of buffered stores; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have parameter NSRC, default 2, giving the number of store-data sources; legal values are 2 to 8. Source 0 is MEM-stage register data and source 1 is WB write data.
REQ-003 The block SHALL have parameter ADDR_W, default 32, giving the byte-address width.
REQ-004 The block SHALL have these ports:
- clk  in  1  -- the single clock; all state changes on its rising edge.
- rst_n  in  1  -- reset, asynchronous and active-low.
- st_valid  in  1  -- a store is issued from the MEM stage this cycle.
- st_addr  in  ADDR_W  -- store byte address.
- st_size  in  2  -- store size: 00 byte, 01 half, 10 word, 11 reserved.
- src_data  in  NSRC*32  -- packed store-data sources; source k occupies bits [32k+31:32k].
- src_sel  in  max(1,$clog2(NSRC))  -- forwarding select.
- st_stall  out  1  -- the pipeline must hold the store.
- st_err  out  1  -- the store was misaligned and dropped.
- dc_valid  out  1  -- a D-cache write request is pending.
- dc_ready  in  1  -- the D-cache accepts the request.
- dc_addr  out  ADDR_W  -- word-aligned write address; bits [1:0] are 0.
- dc_wdata  out  32  -- lane-aligned write data.
- dc_be  out  4  -- byte enables, active high.
- ld_valid  in  1  -- a load is probing the buffer.
- ld_addr  in  ADDR_W  -- load byte address.
- ld_hazard  out  1  -- the load conflicts with a buffered store.
- count  out  $clog2(DEPTH+1)  -- number of occupied entries.

Function
REQ-005 The selected data SHALL be src_data source src_sel; if src_sel >= NSRC, source 0 SHALL be used.
REQ-006 Byte stores SHALL place data[7:0] in all four lanes, with dc_be = 4'b0001 << st_addr[1:0].
REQ-007 Half stores SHALL place data[15:0] in both halves, with dc_be = 4'b0011 << st_addr[1:0].
REQ-008 Word stores SHALL pass the data unchanged, with dc_be = 4'b1111.
REQ-009 A store SHALL be misaligned if:
- it is a half store with st_addr[0] = 1, or
- it is a word store with st_addr[1:0] != 0, or
- st_size = 11.
REQ-010 A misaligned store with st_valid = 1 and st_stall = 0 SHALL NOT be written into the buffer, and st_err SHALL be registered high for exactly the next cycle.
REQ-011 An aligned store SHALL be written into the buffer when st_valid = 1 and st_stall = 0; each entry holds {word address, data, byte enables}.
REQ-012 st_stall SHALL equal st_valid AND (count == DEPTH). It SHALL be computed from registered state only, with no combinational path from dc_ready, so a full buffer stalls even in a cycle where it is also popping.
REQ-013 dc_valid SHALL equal (count != 0), and dc_addr, dc_wdata and dc_be SHALL come from the head entry.
REQ-014 An entry written into an empty buffer SHALL appear on dc_valid in the following cycle; store data never bypasses the buffer in the same cycle.
REQ-015 The head entry SHALL be removed when dc_valid = 1 and dc_ready = 1.
REQ-016 While dc_valid = 1 and dc_ready = 0, dc_addr, dc_wdata and dc_be SHALL stay stable.
REQ-017 When a write and a remove happen in the same cycle, count SHALL stay the same; the write goes to the tail and the remove takes the head.
REQ-018 The read and write pointers SHALL wrap modulo DEPTH. Stores SHALL reach the D-cache in issue order, with no coalescing.
REQ-019 ld_hazard SHALL be combinational and equal ld_valid AND (some occupied entry has a word address equal to ld_addr[ADDR_W-1:2]).
REQ-020 The entry being removed in the current cycle SHALL still count for ld_hazard; the store being written in the current cycle SHALL NOT.
REQ-021 A remove from an empty buffer, or a write to a full buffer, SHALL be impossible by construction; no state changes in that case.

Reset
REQ-022 When rst_n is low, asynchronously:
- pointers = 0 and count = 0,
- st_err = 0,
- every entry is marked invalid,
- therefore dc_valid = 0 and ld_hazard = 0.
REQ-023 A reset during operation SHALL discard all buffered stores without issuing any D-cache write.
REQ-024 After reset the block SHALL accept a store in the first cycle with rst_n high.

Verification
REQ-025 Store byte with addr 0x103, src_sel = 1, src1 = 0x000000AB, dc_ready = 1 -> one cycle later dc_valid = 1, dc_addr = 0x100, dc_wdata = 0xABABABAB, dc_be = 4'b1000; count then returns to 0.
REQ-026 With DEPTH = 4 and dc_ready = 0, issue 5 word stores -> count reaches 4 and st_stall = 1 on the 5th. Raise dc_ready -> the 5th store is accepted one cycle after the first remove, and the order is preserved.
REQ-027 Half store to 0x202 and word store to 0x205 -> the first is accepted with dc_be = 4'b1100; the second gives an st_err pulse of one cycle and count is unchanged.
REQ-028 Buffer holds word address 0x300 and dc_ready = 0; ld_addr = 0x302 with ld_valid = 1 -> ld_hazard = 1. ld_addr = 0x304 -> ld_hazard = 0.
REQ-029 Buffer is full with dc_ready = 1 and st_valid = 1 -> st_stall = 1 in that cycle; count goes to DEPTH-1, the next store is accepted, and the pointers wrap correctly over more than 2*DEPTH stores.
REQ-030 rst_n is pulsed low while 3 entries are pending -> dc_valid = 0 immediately, count = 0, and no D-cache write occurs.
